// File: rtl/risc_multicycle_sequencer_if.sv
// Handshake and control bundle between the multi-cycle sequencer and the
// instruction source, decode, ALU, data memory and register file.
interface risc_multicycle_sequencer_if;
    logic        start;
    logic [31:0] inst;
    logic        imem_rdy;
    logic        dmem_rdy;
    logic        zero;
    logic [31:0] pc;
    logic        imem_req;
    logic        dec_en;
    logic        alu_en;
    logic        dmem_req;
    logic        dmem_we;
    logic        reg_we;
    logic [31:0] ir;
    logic [31:0] retired;
    logic        busy;
    logic        halted;
    logic        fault;

    modport master (
        input  start, inst, imem_rdy, dmem_rdy, zero,
        output pc, imem_req, dec_en, alu_en, dmem_req, dmem_we, reg_we,
               ir, retired, busy, halted, fault
    );

    modport slave (
        output start, inst, imem_rdy, dmem_rdy, zero,
        input  pc, imem_req, dec_en, alu_en, dmem_req, dmem_we, reg_we,
               ir, retired, busy, halted, fault
    );
endinterface

// File: rtl/risc_multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer; owns the PC, the
// instruction register and the retired-instruction count.
module risc_multicycle_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    risc_multicycle_sequencer_if.master        bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_e;

    typedef enum logic [2:0] {
        C_RTYPE, C_ITYPE, C_LOAD, C_STORE, C_BEQ, C_JUMP, C_HALT
    } iclass_e;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] retired_q, retired_d;
    logic        fault_q, fault_d;
    logic [15:0] wait_q, wait_d;

    iclass_e     iclass;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] jump_target;

    logic imem_req, dec_en, alu_en, dmem_req, dmem_we, reg_we, busy, halted;

    always_comb begin : classify
        case (ir_q[31:26])
            6'h00:   iclass = C_RTYPE;
            6'h23:   iclass = C_LOAD;
            6'h2B:   iclass = C_STORE;
            6'h04:   iclass = C_BEQ;
            6'h02:   iclass = C_JUMP;
            6'h3F:   iclass = C_HALT;
            default: iclass = C_ITYPE;
        endcase
    end

    assign pc_plus4    = pc_q + 32'd4;
    assign br_target   = pc_plus4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
    assign jump_target = {pc_q[31:28], ir_q[25:0], 2'b00};

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge values computed by the combinational processes.
    always_ff @(posedge clk or posedge rst) begin : state_reg
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            retired_q <= '0;
            fault_q   <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            fault_q   <= fault_d;
            wait_q    <= wait_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin : next_state
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        fault_d   = fault_q;
        wait_d    = '0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (bus.start) begin
                    state_d   = S_FETCH;
                    pc_d      = RESET_PC;
                    retired_d = '0;
                    fault_d   = 1'b0;
                end
            end
            S_FETCH: begin
                if (bus.imem_rdy) begin
                    ir_d    = bus.inst;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                case (iclass)
                    C_LOAD, C_STORE: state_d = S_MEM;
                    C_BEQ: begin
                        state_d   = S_FETCH;
                        pc_d      = bus.zero ? br_target : pc_plus4;
                        retired_d = retired_q + 32'd1;
                    end
                    C_JUMP: begin
                        state_d   = S_FETCH;
                        pc_d      = jump_target;
                        retired_d = retired_q + 32'd1;
                    end
                    C_HALT: begin
                        state_d   = S_HALT;
                        retired_d = retired_q + 32'd1;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (bus.dmem_rdy) begin
                    if (iclass == C_STORE) begin
                        state_d   = S_FETCH;
                        pc_d      = pc_plus4;
                        retired_d = retired_q + 32'd1;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_WB: begin
                state_d   = S_FETCH;
                pc_d      = pc_plus4;
                retired_d = retired_q + 32'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Enables are pure functions of state so an async reset drops them at once.
    always_comb begin : outputs
        imem_req = 1'b0;
        dec_en   = 1'b0;
        alu_en   = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        busy     = 1'b1;
        halted   = 1'b0;
        case (state_q)
            S_FETCH:  imem_req = 1'b1;
            S_DECODE: dec_en   = 1'b1;
            S_EXEC:   alu_en   = 1'b1;
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (iclass == C_STORE);
            end
            S_WB:     reg_we   = 1'b1;
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            default:  busy     = 1'b0;
        endcase
    end

    assign bus.pc       = pc_q;
    assign bus.ir       = ir_q;
    assign bus.retired  = retired_q;
    assign bus.fault    = fault_q;
    assign bus.imem_req = imem_req;
    assign bus.dec_en   = dec_en;
    assign bus.alu_en   = alu_en;
    assign bus.dmem_req = dmem_req;
    assign bus.dmem_we  = dmem_we;
    assign bus.reg_we   = reg_we;
    assign bus.busy     = busy;
    assign bus.halted   = halted;
endmodule

// File: tb/tb_risc_multicycle_sequencer.sv
// Bench for risc_multicycle_sequencer: vector table, hand-written corner
// sequences and a randomized run against an instruction-level reference model.
`timescale 1ns/1ps
module tb_risc_multicycle_sequencer;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    risc_multicycle_sequencer_if bus0();
    risc_multicycle_sequencer_if bus1();

    // Second instance shares all stimulus; it differs in RESET_PC and TIMEOUT.
    assign bus1.start    = bus0.start;
    assign bus1.inst     = bus0.inst;
    assign bus1.imem_rdy = bus0.imem_rdy;
    assign bus1.dmem_rdy = bus0.dmem_rdy;
    assign bus1.zero     = bus0.zero;

    risc_multicycle_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus0.master)
    );
    risc_multicycle_sequencer #(.RESET_PC(32'hF000_0000), .TIMEOUT(3)) dut_hi (
        .clk(clk), .rst(rst), .bus(bus1.master)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] en0();
        return {bus0.imem_req, bus0.dec_en, bus0.alu_en, bus0.dmem_req, bus0.reg_we};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus0.start = 1'b0; bus0.inst = '0; bus0.imem_rdy = 1'b0;
        bus0.dmem_rdy = 1'b0; bus0.zero = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic do_start();
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
    endtask

    // Runs one instruction from FETCH until the next FETCH or HALT.
    task automatic exec_instr(input logic [31:0] instr, input logic z, input int iwait,
                              input int dwait, input bit noise, output int cycles,
                              output int regwe_n, output int memreq_n, output int memwe_n,
                              output bit onehot_ok);
        int  fcnt = 0;
        int  mcnt = 0;
        bit  fetched = 1'b0;
        logic [4:0] en;
        cycles = 0; regwe_n = 0; memreq_n = 0; memwe_n = 0; onehot_ok = 1'b1;
        while (cycles < 200) begin
            en = en0();
            if ($countones(en) > 1 || bus0.busy !== (en != 5'd0)) onehot_ok = 1'b0;
            if (bus0.reg_we)   regwe_n++;
            if (bus0.dmem_req) memreq_n++;
            if (bus0.dmem_we)  memwe_n++;
            if (bus0.dec_en)   fetched = 1'b1;
            bus0.inst     = noise ? $urandom : instr;
            bus0.imem_rdy = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus0.dmem_rdy = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus0.zero     = noise ? 1'($urandom_range(0, 1)) : z;
            bus0.start    = noise && bus0.busy && ($urandom_range(0, 3) == 0);
            if (bus0.imem_req) begin
                bus0.imem_rdy = (fcnt >= iwait);
                if (bus0.imem_rdy) bus0.inst = instr;
                fcnt++;
            end
            if (bus0.dmem_req) begin
                bus0.dmem_rdy = (mcnt >= dwait);
                mcnt++;
            end
            if (bus0.alu_en) bus0.zero = z;
            tick();
            cycles++;
            if ((fetched && bus0.imem_req) || bus0.halted) break;
        end
        bus0.start = 1'b0; bus0.imem_rdy = 1'b0; bus0.dmem_rdy = 1'b0;
    endtask

    typedef struct {
        logic [31:0] inst;
        logic        z;
        int          iwait;
        int          dwait;
        int          cycles;
        logic [31:0] pc;
        logic [31:0] retired;
        logic        halted;
        logic        fault;
        int          regwe;
        int          memreq;
        int          memwe;
        logic [31:0] ir;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, rw, mr, mw;
        bit oh;
        logic [4:0] exp_seq [5];

        // inst, zero, iwait, dwait | cycles, pc, retired, halted, fault, reg_we, dmem_req, dmem_we, ir
        vecs[0]  = '{32'h0000_0020, 1'b0, 0,   0,   4,  32'h4,         1, 1'b0, 1'b0, 1, 0,  0, 32'h0000_0020};
        vecs[1]  = '{32'h8C00_0000, 1'b0, 0,   3,   8,  32'h4,         1, 1'b0, 1'b0, 1, 4,  0, 32'h8C00_0000};
        vecs[2]  = '{32'hAC00_0000, 1'b0, 0,   0,   4,  32'h4,         1, 1'b0, 1'b0, 0, 1,  1, 32'hAC00_0000};
        vecs[3]  = '{32'hAC00_0000, 1'b0, 1,   2,   7,  32'h4,         1, 1'b0, 1'b0, 0, 3,  3, 32'hAC00_0000};
        vecs[4]  = '{32'h1000_FFFF, 1'b1, 0,   0,   3,  32'h0,         1, 1'b0, 1'b0, 0, 0,  0, 32'h1000_FFFF};
        vecs[5]  = '{32'h1000_FFFF, 1'b0, 0,   0,   3,  32'h4,         1, 1'b0, 1'b0, 0, 0,  0, 32'h1000_FFFF};
        vecs[6]  = '{32'h1000_0003, 1'b1, 0,   0,   3,  32'h10,        1, 1'b0, 1'b0, 0, 0,  0, 32'h1000_0003};
        vecs[7]  = '{32'h1000_FFFE, 1'b1, 0,   0,   3,  32'hFFFF_FFFC, 1, 1'b0, 1'b0, 0, 0,  0, 32'h1000_FFFE};
        vecs[8]  = '{32'h0800_0010, 1'b0, 0,   0,   3,  32'h40,        1, 1'b0, 1'b0, 0, 0,  0, 32'h0800_0010};
        vecs[9]  = '{32'hFC00_0000, 1'b0, 0,   0,   3,  32'h0,         1, 1'b1, 1'b0, 0, 0,  0, 32'hFC00_0000};
        vecs[10] = '{32'h2000_0005, 1'b0, 2,   0,   6,  32'h4,         1, 1'b0, 1'b0, 1, 0,  0, 32'h2000_0005};
        vecs[11] = '{32'h0000_0020, 1'b0, 100, 0,   16, 32'h0,         0, 1'b1, 1'b1, 0, 0,  0, 32'h0};
        vecs[12] = '{32'h0000_0020, 1'b0, 15,  0,   19, 32'h4,         1, 1'b0, 1'b0, 1, 0,  0, 32'h0000_0020};
        vecs[13] = '{32'h8C00_0000, 1'b0, 0,   100, 19, 32'h0,         0, 1'b1, 1'b1, 0, 16, 0, 32'h8C00_0000};
        vecs[14] = '{32'h8C00_0000, 1'b0, 0,   15,  20, 32'h4,         1, 1'b0, 1'b0, 1, 16, 0, 32'h8C00_0000};
        vecs[15] = '{32'h0BFF_FFFF, 1'b0, 0,   0,   3,  32'h0FFF_FFFC, 1, 1'b0, 1'b0, 0, 0,  0, 32'h0BFF_FFFF};

        // Reset state
        do_reset();
        check("rst_pc", bus0.pc, 32'h0);
        check("rst_ir", bus0.ir, 32'h0);
        check("rst_retired", bus0.retired, 32'h0);
        check("rst_fault", 32'(bus0.fault), 32'h0);
        check("rst_enables", 32'(en0()), 32'h0);
        check("rst_busy_halted", {30'h0, bus0.busy, bus0.halted}, 32'h0);
        check("rst_pc_hi", bus1.pc, 32'hF000_0000);

        // R-type with rdy tied high: enables walk F, D, E, W in order
        exp_seq = '{5'b10000, 5'b01000, 5'b00100, 5'b00001, 5'b10000};
        bus0.imem_rdy = 1'b1; bus0.dmem_rdy = 1'b1; bus0.inst = 32'h0000_0020;
        do_start();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rtype_en_%0d", i), 32'(en0()), 32'(exp_seq[i]));
            if (i < 4) tick();
        end
        check("rtype_pc", bus0.pc, 32'h4);
        check("rtype_retired", bus0.retired, 32'h1);
        bus0.imem_rdy = 1'b0; bus0.dmem_rdy = 1'b0;

        // Vector table, each from a fresh reset and start
        foreach (vecs[k]) begin
            do_reset();
            do_start();
            exec_instr(vecs[k].inst, vecs[k].z, vecs[k].iwait, vecs[k].dwait, 1'b0,
                       cyc, rw, mr, mw, oh);
            check($sformatf("v%0d_cycles", k), cyc, vecs[k].cycles);
            check($sformatf("v%0d_pc", k), bus0.pc, vecs[k].pc);
            check($sformatf("v%0d_retired", k), bus0.retired, vecs[k].retired);
            check($sformatf("v%0d_halted", k), 32'(bus0.halted), 32'(vecs[k].halted));
            check($sformatf("v%0d_fault", k), 32'(bus0.fault), 32'(vecs[k].fault));
            check($sformatf("v%0d_reg_we", k), rw, vecs[k].regwe);
            check($sformatf("v%0d_dmem_req", k), mr, vecs[k].memreq);
            check($sformatf("v%0d_dmem_we", k), mw, vecs[k].memwe);
            check($sformatf("v%0d_ir", k), bus0.ir, vecs[k].ir);
            check($sformatf("v%0d_onehot", k), 32'(oh), 32'h1);
        end

        // BEQ at pc=8, taken then not taken
        do_reset();
        do_start();
        exec_instr(32'h0000_0020, 1'b0, 0, 0, 1'b0, cyc, rw, mr, mw, oh);
        exec_instr(32'h0000_0020, 1'b0, 0, 0, 1'b0, cyc, rw, mr, mw, oh);
        check("beq_pre_pc", bus0.pc, 32'h8);
        exec_instr(32'h1000_FFFF, 1'b1, 0, 0, 1'b0, cyc, rw, mr, mw, oh);
        check("beq_taken_pc", bus0.pc, 32'h8);
        check("beq_taken_reg_we", rw, 0);
        exec_instr(32'h1000_FFFF, 1'b0, 0, 0, 1'b0, cyc, rw, mr, mw, oh);
        check("beq_not_taken_pc", bus0.pc, 32'hC);
        check("beq_not_taken_reg_we", rw, 0);
        check("beq_retired", bus0.retired, 32'h4);

        // JUMP from pc=F000_0000 followed by HALT (high-RESET_PC instance)
        do_reset();
        do_start();
        exec_instr(32'h0800_0010, 1'b0, 0, 0, 1'b0, cyc, rw, mr, mw, oh);
        check("jump_hi_pc", bus1.pc, 32'hF000_0040);
        check("jump_lo_pc", bus0.pc, 32'h40);
        exec_instr(32'hFC00_0000, 1'b0, 0, 0, 1'b0, cyc, rw, mr, mw, oh);
        check("halt_hi_halted", 32'(bus1.halted), 32'h1);
        check("halt_hi_busy", 32'(bus1.busy), 32'h0);
        check("halt_hi_retired", bus1.retired, 32'h2);
        check("halt_hi_pc", bus1.pc, 32'hF000_0040);
        tick(); tick(); tick();
        check("halt_hold_halted", 32'(bus0.halted), 32'h1);
        check("halt_hold_pc", bus0.pc, 32'h40);

        // Fetch timeout: TIMEOUT=3 instance, then TIMEOUT=16 instance, then restart
        do_reset();
        do_start();
        tick(); tick();
        check("to3_not_yet", 32'(bus1.fault), 32'h0);
        tick();
        check("to3_fault", 32'(bus1.fault), 32'h1);
        for (int i = 0; i < 12; i++) tick();
        check("to16_not_yet", 32'(bus0.fault), 32'h0);
        check("to16_busy", 32'(bus0.busy), 32'h1);
        tick();
        check("to16_fault", 32'(bus0.fault), 32'h1);
        check("to16_halted", 32'(bus0.halted), 32'h1);
        check("to16_pc", bus0.pc, 32'h0);
        do_start();
        check("restart_fault", 32'(bus0.fault), 32'h0);
        check("restart_fetch", 32'(en0()), 32'b10000);
        check("restart_pc", bus0.pc, 32'h0);
        check("restart_hi_pc", bus1.pc, 32'hF000_0000);
        check("restart_hi_fault", 32'(bus1.fault), 32'h0);

        // Reset pulse in MEM of a STORE
        do_reset();
        do_start();
        exec_instr(32'h0000_0020, 1'b0, 0, 0, 1'b0, cyc, rw, mr, mw, oh);
        bus0.imem_rdy = 1'b1; bus0.inst = 32'hAC00_0000;
        tick(); tick(); tick();
        bus0.imem_rdy = 1'b0;
        check("store_in_mem", {30'h0, bus0.dmem_req, bus0.dmem_we}, 32'h3);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_enables", 32'(en0()), 32'h0);
        check("rst_mid_dmem_we", 32'(bus0.dmem_we), 32'h0);
        check("rst_mid_busy", 32'(bus0.busy), 32'h0);
        check("rst_mid_pc", bus0.pc, 32'h0);
        check("rst_mid_retired", bus0.retired, 32'h0);
        check("rst_mid_ir", bus0.ir, 32'h0);
        bus0.start = 1'b1;
        tick(); tick();
        check("rst_held_start_ignored", {27'h0, en0()}, 32'h0);
        rst = 1'b0;
        bus0.start = 1'b0;
        tick();
        check("rst_release_idle", {26'h0, en0(), bus0.busy}, 32'h0);
        do_start();
        check("rst_then_start", 32'(en0()), 32'b10000);

        // Randomized run against an instruction-level model
        begin
            logic [31:0] m_pc, m_ret, m_ir, instr;
            logic        m_fault, m_halt, z;
            logic signed [15:0] imm;
            int cls, iw, dw, exp_cyc;
            bit is_mem;
            logic [5:0] op;
            do_reset();
            do_start();
            m_pc = 32'h0; m_ret = 32'h0; m_ir = 32'h0;
            for (int n = 0; n < 300; n++) begin
                cls = $urandom_range(0, 6);
                instr = $urandom;
                case (cls)
                    0: instr[31:26] = 6'h00;
                    1: begin
                        op = 6'($urandom_range(0, 63));
                        if (op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F}) op = 6'h08;
                        instr[31:26] = op;
                    end
                    2: instr[31:26] = 6'h23;
                    3: instr[31:26] = 6'h2B;
                    4: instr[31:26] = 6'h04;
                    5: instr[31:26] = 6'h02;
                    default: instr[31:26] = 6'h3F;
                endcase
                z  = 1'($urandom_range(0, 1));
                iw = ($urandom_range(0, 19) == 0) ? TO + $urandom_range(0, 3) : $urandom_range(0, 3);
                dw = ($urandom_range(0, 19) == 0) ? TO + $urandom_range(0, 3) : $urandom_range(0, 3);
                is_mem = (cls == 2) || (cls == 3);
                m_fault = 1'b0; m_halt = 1'b0;
                if (iw >= TO) begin
                    exp_cyc = TO; m_fault = 1'b1; m_halt = 1'b1;
                end else if (is_mem && dw >= TO) begin
                    exp_cyc = iw + 3 + TO; m_fault = 1'b1; m_halt = 1'b1; m_ir = instr;
                end else begin
                    m_ir = instr;
                    m_ret = m_ret + 1;
                    case (cls)
                        2:       exp_cyc = 5 + iw + dw;
                        3:       exp_cyc = 4 + iw + dw;
                        4, 5, 6: exp_cyc = 3 + iw;
                        default: exp_cyc = 4 + iw;
                    endcase
                    imm = instr[15:0];
                    if (cls == 4)      m_pc = z ? m_pc + 32'd4 + 32'(imm) * 32'd4 : m_pc + 32'd4;
                    else if (cls == 5) m_pc = (m_pc & 32'hF000_0000) + (32'(instr[25:0]) << 2);
                    else if (cls == 6) m_halt = 1'b1;
                    else               m_pc = m_pc + 32'd4;
                end
                exec_instr(instr, z, iw, dw, 1'b1, cyc, rw, mr, mw, oh);
                check($sformatf("rnd%0d_cycles", n), cyc, exp_cyc);
                check($sformatf("rnd%0d_pc", n), bus0.pc, m_pc);
                check($sformatf("rnd%0d_retired", n), bus0.retired, m_ret);
                check($sformatf("rnd%0d_ir", n), bus0.ir, m_ir);
                check($sformatf("rnd%0d_flags", n), {30'h0, bus0.halted, bus0.fault},
                      {30'h0, m_halt, m_fault});
                if (m_halt) begin
                    do_start();
                    m_pc = 32'h0; m_ret = 32'h0;
                    check($sformatf("rnd%0d_restart", n), {26'h0, en0(), bus0.fault}, 32'b100000);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
